// File: rtl/digital_lock_pkg.sv
// Shared state encodings and sizing helper for the programmable code lock.
// Constants only; no timing or flow-control behaviour lives here.
package digital_lock_pkg;

  localparam logic [2:0] ST_LOCKED   = 3'd0;
  localparam logic [2:0] ST_CHECK    = 3'd1;
  localparam logic [2:0] ST_UNLOCKED = 3'd2;
  localparam logic [2:0] ST_PROG     = 3'd3;
  localparam logic [2:0] ST_LOCKOUT  = 3'd4;

  // Ceiling log2 with a floor of zero; used for every counter and digit width.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_press_detect.sv
// Turns active-low push buttons into single-cycle press events carrying the key index.
// Combinational press against a one-cycle-old key image; no backpressure, every cycle is sampled.
module key_press_detect
  import digital_lock_pkg::*;
#(
  parameter int KEY_COUNT = 4,
  localparam int DW = clog2(KEY_COUNT)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [KEY_COUNT-1:0] key,
  output logic                 press,
  output logic [DW-1:0]        digit
);

  logic [KEY_COUNT-1:0] prev_key;
  logic [KEY_COUNT-1:0] pressed;
  logic                 single;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_key <= '1;
    end else begin
      prev_key <= key;
    end
  end

  assign pressed = ~key;

  // A chord never yields a press: it must return to all-released before the next event.
  assign single = (pressed != '0) && ((pressed & (pressed - KEY_COUNT'(1))) == '0);
  assign press  = (&prev_key) && single;

  always_comb begin
    digit = '0;
    for (int i = 0; i < KEY_COUNT; i++) begin
      if (pressed[i]) begin
        digit = DW'(i);
      end
    end
  end

endmodule

// File: rtl/code_lock_prog.sv
// Digit-code lock with consecutive-fail lockout and in-place reprogramming of the code.
// Unlock/err decided two edges after the final digit; no backpressure, presses outside entry states are dropped.
module code_lock_prog
  import digital_lock_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int KEY_COUNT      = 4,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter logic [DIGITS*clog2(KEY_COUNT)-1:0] DEFAULT_CODE = 8'b11_01_00_10,
  localparam int DW = clog2(KEY_COUNT),
  localparam int CW = clog2(DIGITS + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [KEY_COUNT-1:0] key,
  input  logic                 lock_req,
  input  logic                 prog,
  output logic                 locked,
  output logic                 lockout,
  output logic                 error,
  output logic                 prog_done,
  output logic [CW-1:0]        digit_cnt,
  output logic [2:0]           state
);

  localparam int CODE_W = DIGITS * DW;
  localparam int FW     = clog2(MAX_FAILS + 1);
  localparam int TW     = clog2(LOCKOUT_CYCLES + 1);

  localparam logic [CW-1:0] LAST_POS  = CW'(DIGITS - 1);
  localparam logic [FW-1:0] LAST_FAIL = FW'(MAX_FAILS - 1);
  localparam logic [TW-1:0] TMR_LOAD  = TW'(LOCKOUT_CYCLES - 1);

  logic              press;
  logic [DW-1:0]     digit;
  logic [CODE_W-1:0] entry;
  logic [CODE_W-1:0] shadow;
  logic [CODE_W-1:0] code;
  logic [FW-1:0]     fail_cnt;
  logic [TW-1:0]     timer;

  key_press_detect #(
    .KEY_COUNT(KEY_COUNT)
  ) u_kpd (
    .clock(clock),
    .reset(reset),
    .key  (key),
    .press(press),
    .digit(digit)
  );

  // First-entered digit lives in the most significant slot, matching DEFAULT_CODE.
  function automatic logic [CODE_W-1:0] put_digit(input logic [CODE_W-1:0] word,
                                                 input logic [CW-1:0]     pos,
                                                 input logic [DW-1:0]     d);
    logic [CODE_W-1:0] w;
    w = word;
    for (int i = 0; i < DIGITS; i++) begin
      if (pos == CW'(i)) begin
        w[(DIGITS-1-i)*DW +: DW] = d;
      end
    end
    return w;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_LOCKED;
      digit_cnt <= '0;
      entry     <= '0;
      shadow    <= '0;
      code      <= DEFAULT_CODE;
      fail_cnt  <= '0;
      timer     <= '0;
      error     <= 1'b0;
      prog_done <= 1'b0;
    end else begin
      error     <= 1'b0;
      prog_done <= 1'b0;
      case (state)
        ST_LOCKED: begin
          if (press) begin
            entry     <= put_digit(entry, digit_cnt, digit);
            digit_cnt <= digit_cnt + CW'(1);
            if (digit_cnt == LAST_POS) begin
              state <= ST_CHECK;
            end
          end
        end

        // Full-width compare so timing does not leak which digit was wrong.
        ST_CHECK: begin
          digit_cnt <= '0;
          if (entry == code) begin
            state    <= ST_UNLOCKED;
            fail_cnt <= '0;
          end else begin
            error    <= 1'b1;
            fail_cnt <= fail_cnt + FW'(1);
            if (fail_cnt == LAST_FAIL) begin
              state <= ST_LOCKOUT;
              timer <= TMR_LOAD;
            end else begin
              state <= ST_LOCKED;
            end
          end
        end

        ST_UNLOCKED: begin
          if (lock_req) begin
            state     <= ST_LOCKED;
            digit_cnt <= '0;
          end else if (prog) begin
            state     <= ST_PROG;
            digit_cnt <= '0;
          end
        end

        ST_PROG: begin
          if (lock_req) begin
            state     <= ST_LOCKED;
            digit_cnt <= '0;
            shadow    <= '0;
          end else if (press) begin
            shadow <= put_digit(shadow, digit_cnt, digit);
            if (digit_cnt == LAST_POS) begin
              code      <= put_digit(shadow, digit_cnt, digit);
              prog_done <= 1'b1;
              state     <= ST_UNLOCKED;
              digit_cnt <= '0;
            end else begin
              digit_cnt <= digit_cnt + CW'(1);
            end
          end
        end

        ST_LOCKOUT: begin
          if (timer == '0) begin
            state     <= ST_LOCKED;
            fail_cnt  <= '0;
            digit_cnt <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        default: begin
          state     <= ST_LOCKED;
          digit_cnt <= '0;
        end
      endcase
    end
  end

  assign locked  = !((state == ST_UNLOCKED) || (state == ST_PROG));
  assign lockout = (state == ST_LOCKOUT);

endmodule

// File: tb/tb_code_lock_prog.sv
// Directed bench for code_lock_prog: unlock, fail/lockout, programming, chords and async reset.
module tb_code_lock_prog;

  localparam int KC = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [KC-1:0] key;
  logic          lock_req;
  logic          prog;
  logic          locked;
  logic          lockout;
  logic          error;
  logic          prog_done;
  logic [2:0]    digit_cnt;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;
  int cnt;

  always #5 clock = ~clock;

  code_lock_prog dut (
    .clock    (clock),
    .reset    (reset),
    .key      (key),
    .lock_req (lock_req),
    .prog     (prog),
    .locked   (locked),
    .lockout  (lockout),
    .error    (error),
    .prog_done(prog_done),
    .digit_cnt(digit_cnt),
    .state    (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_digit(input int d);
    @(negedge clock);
    key = ~(KC'(1) << d);
    @(negedge clock);
    key = '1;
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    press_digit(a);
    press_digit(b);
    press_digit(c);
    press_digit(d);
  endtask

  task automatic pulse_lock();
    @(negedge clock);
    lock_req = 1'b1;
    @(negedge clock);
    lock_req = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    key      = '1;
    lock_req = 1'b0;
    prog     = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_locked", locked, 1);
    check("rst_lockout", lockout, 0);
    check("rst_error", error, 0);
    check("rst_prog_done", prog_done, 0);
    check("rst_digit_cnt", digit_cnt, 0);
    check("rst_state", state, 0);
    check("rst_code", dut.code, 8'hD2);
    check("rst_fail_cnt", dut.fail_cnt, 0);
    reset = 1'b0;

    // Default code opens two edges after the last digit.
    enter4(3, 1, 0, 2);
    check("ok_check_state", state, 1);
    check("ok_still_locked", locked, 1);
    @(negedge clock);
    check("ok_unlocked", locked, 0);
    check("ok_state", state, 2);
    check("ok_no_error", error, 0);
    pulse_lock();
    check("relock", locked, 1);
    check("relock_state", state, 0);

    // Single wrong code.
    enter4(3, 1, 0, 1);
    @(negedge clock);
    check("bad_error", error, 1);
    check("bad_locked", locked, 1);
    check("bad_digit_cnt", digit_cnt, 0);
    check("bad_fail_cnt", dut.fail_cnt, 1);
    @(negedge clock);
    check("bad_error_pulse", error, 0);

    // Two more wrong codes reach lockout.
    enter4(0, 0, 0, 0);
    @(negedge clock);
    check("bad2_fail_cnt", dut.fail_cnt, 2);
    check("bad2_state", state, 0);
    enter4(1, 1, 1, 1);
    @(negedge clock);
    check("lo_error", error, 1);
    check("lo_lockout", lockout, 1);
    check("lo_state", state, 4);
    cnt = 0;
    while (lockout === 1'b1 && cnt < 1100) begin
      cnt++;
      check("lo_digit_cnt", digit_cnt, 0);
      key      = (cnt < 990 && cnt % 8 == 3) ? ~(KC'(1) << (cnt % 4)) : '1;
      lock_req = (cnt == 100);
      prog     = (cnt == 200);
      @(negedge clock);
    end
    key      = '1;
    lock_req = 1'b0;
    prog     = 1'b0;
    check("lo_duration", cnt, 1000);
    check("lo_exit_state", state, 0);
    check("lo_exit_fail_cnt", dut.fail_cnt, 0);
    check("lo_exit_locked", locked, 1);
    enter4(3, 1, 0, 2);
    @(negedge clock);
    check("lo_after_unlock", locked, 0);

    // Program a new code.
    @(negedge clock);
    prog = 1'b1;
    @(negedge clock);
    prog = 1'b0;
    check("prog_state", state, 3);
    check("prog_locked", locked, 0);
    press_digit(2);
    check("prog_digit_cnt", digit_cnt, 1);
    check("prog_locked_mid", locked, 0);
    press_digit(2);
    press_digit(1);
    press_digit(0);
    check("prog_done_pulse", prog_done, 1);
    check("prog_back_unlocked", state, 2);
    check("prog_code", dut.code, 8'hA4);
    @(negedge clock);
    check("prog_done_clear", prog_done, 0);
    pulse_lock();
    check("prog_relock", locked, 1);
    enter4(3, 1, 0, 2);
    @(negedge clock);
    check("old_code_error", error, 1);
    check("old_code_locked", locked, 1);
    enter4(2, 2, 1, 0);
    @(negedge clock);
    check("new_code_unlock", locked, 0);
    check("new_code_fail_clr", dut.fail_cnt, 0);

    // Async reset in the middle of an entry.
    pulse_lock();
    press_digit(1);
    press_digit(2);
    check("mid_digit_cnt", digit_cnt, 2);
    key = 4'b1110;
    #2 reset = 1'b1;
    #1;
    check("arst_digit_cnt", digit_cnt, 0);
    check("arst_state", state, 0);
    check("arst_locked", locked, 1);
    check("arst_code", dut.code, 8'hD2);
    check("arst_prev_key", dut.u_kpd.prev_key, 4'hF);
    check("arst_error", error, 0);
    check("arst_lockout", lockout, 0);
    key = '1;
    @(negedge clock);
    reset = 1'b0;

    // Chorded keys produce no digit, then the default code opens.
    @(negedge clock);
    key = 4'b1100;
    @(negedge clock);
    key = 4'b1101;
    @(negedge clock);
    key = '1;
    check("chord_digit_cnt", digit_cnt, 0);
    @(negedge clock);
    check("chord_digit_cnt2", digit_cnt, 0);
    enter4(3, 1, 0, 2);
    @(negedge clock);
    check("chord_unlock", locked, 0);

    // Async reset while programming drops the partial code.
    @(negedge clock);
    prog = 1'b1;
    @(negedge clock);
    prog = 1'b0;
    press_digit(2);
    press_digit(2);
    check("pmid_digit_cnt", digit_cnt, 2);
    check("pmid_state", state, 3);
    #2 reset = 1'b1;
    #1;
    check("parst_locked", locked, 1);
    check("parst_state", state, 0);
    check("parst_digit_cnt", digit_cnt, 0);
    check("parst_prog_done", prog_done, 0);
    check("parst_code", dut.code, 8'hD2);
    @(negedge clock);
    reset = 1'b0;
    enter4(2, 2, 1, 0);
    @(negedge clock);
    check("parst_new_rejected", error, 1);
    enter4(3, 1, 0, 2);
    @(negedge clock);
    check("parst_default_unlock", locked, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/code_lock_prog.md
CODE_LOCK_PROG -- requirements
Module: code_lock_prog

Interface
REQ-001 Parameter DIGITS, default 4, number of digits in the unlock code (range 1..16).
REQ-002 Parameter KEY_COUNT, default 4, number of push-button keys (range 2..16); DW = clog2(KEY_COUNT) is the digit width.
REQ-003 Parameter MAX_FAILS, default 3, number of consecutive wrong codes that triggers lockout (range 1..15).
REQ-004 Parameter LOCKOUT_CYCLES, default 1000, duration of lockout in clock cycles (minimum 1).
REQ-005 Parameter DEFAULT_CODE, default digits {3,1,0,2} (first-entered digit first), width DIGITS*DW, the code loaded at reset.
REQ-006 clock  input  1  single system clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 key  input  KEY_COUNT  active-low push buttons, synchronous to clock; bit i low = key i pressed.
REQ-009 lock_req  input  1  active-high request to relock or abort programming.
REQ-010 prog  input  1  active-high request to enter code-programming mode.
REQ-011 locked  output  1  high whenever the lock is not open.
REQ-012 lockout  output  1  high while the lockout timer runs.
REQ-013 error  output  1  one-cycle pulse on each wrong code entry.
REQ-014 prog_done  output  1  one-cycle pulse when a new code has been stored.
REQ-015 digit_cnt  output  clog2(DIGITS+1)  digits entered so far in the current entry.
REQ-016 state  output  3  current state encoding, for debug.

Function
REQ-017 A press event is the cycle in which the registered previous key value is all ones and the current key value has exactly one zero bit; the digit value is the index of that bit.
REQ-018 Any key pattern with more than one zero bit is ignored and produces no press event until key returns to all ones.
REQ-019 States: LOCKED, CHECK, UNLOCKED, PROG, LOCKOUT.
REQ-020 In LOCKED, each press event stores the digit at position digit_cnt and increments digit_cnt; the DIGITS-th press moves to CHECK.
REQ-021 CHECK lasts exactly one cycle and compares all DIGITS digits against the code register with no early abort; press events in CHECK are ignored.
REQ-022 On a match, the machine moves to UNLOCKED and clears the fail counter; locked falls on the second rising edge after the final press is sampled.
REQ-023 On a mismatch, the machine pulses error for one cycle and increments the fail counter; it moves to LOCKOUT if the counter reaches MAX_FAILS, otherwise to LOCKED; digit_cnt clears in either case.
REQ-024 In LOCKOUT, key, prog and lock_req are ignored; after exactly LOCKOUT_CYCLES cycles the machine moves to LOCKED with the fail counter cleared.
REQ-025 In UNLOCKED, press events are ignored; lock_req moves to LOCKED; prog moves to PROG; if both are high in the same cycle, lock_req wins.
REQ-026 In PROG, locked stays low and press events fill a shadow register; on the DIGITS-th digit the shadow is copied to the code register, prog_done pulses, and the machine returns to UNLOCKED.
REQ-027 lock_req in PROG discards the shadow register, keeps the old code, and moves to LOCKED.
REQ-028 locked is low only in UNLOCKED and PROG.

Reset
REQ-029 While reset is high: state is LOCKED, locked=1, lockout=0, error=0, prog_done=0, digit_cnt=0, the fail counter and lockout timer are 0, the code register holds DEFAULT_CODE, and the previous-key register is all ones.
REQ-030 Reset asserted mid-entry, mid-lockout or mid-programming takes effect immediately, without waiting for a clock edge.

Structure
REQ-031 Package digital_lock_pkg holds the state encodings (LOCKED=0, CHECK=1, UNLOCKED=2, PROG=3, LOCKOUT=4) and the clog2 constant function.
REQ-032 Sub-module key_press_detect holds the previous-key register, press detection and one-hot-to-index encoding; it outputs press and digit.

Verification
REQ-033 Reset, then press 3,1,0,2 -> locked=0 two edges after the last press; error never pulses.
REQ-034 Press 3,1,0,1 -> error is high for one cycle, locked=1, digit_cnt=0, and the fail counter is 1.
REQ-035 Three wrong codes -> lockout=1 for exactly 1000 cycles; presses during lockout leave digit_cnt at 0; afterwards the correct code unlocks.
REQ-036 Unlock, assert prog, press 2,2,1,0 -> prog_done pulses; assert lock_req; the old code 3,1,0,2 then fails and 2,2,1,0 unlocks.
REQ-037 Press keys 0 and 1 together, then 3,1,0,2 -> the dual press is ignored and the lock opens.
REQ-038 Assert reset after two digits of entry, and separately mid-PROG -> all outputs return to reset values immediately and the code is DEFAULT_CODE.
